// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
// The adder path is multicycle: operands are held EXEC_CYCLES cycles before the sum is sampled.
//
// state | meaning
// IDLE  | arbitrate; ready strobes the granted requester, operands captured on handshake
// EXEC  | operands held on the adder, exec counter counts down to the sample point
// RESP  | result presented on the response channel until the sink accepts it

module ripple_carry_adder_19bit #(
   parameter int WIDTH = 19
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);
   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   for (genvar k = 0; k < WIDTH; k++) begin : g_bit
      assign sum[k]     = a[k] ^ b[k] ^ carry[k];
      assign carry[k+1] = (a[k] & b[k]) | (carry[k] & (a[k] ^ b[k]));
   end

   assign carry_out = carry[WIDTH];
endmodule

module adder_share_arbiter #(
   parameter int WIDTH       = 19,
   parameter int NUM_REQ     = 4,
   parameter int ID_W        = $clog2(NUM_REQ),
   parameter int EXEC_CYCLES = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_term1,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_term2,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic                     o_rsp_valid,
   output logic [ID_W-1:0]          o_rsp_id,
   output logic [WIDTH:0]           o_rsp_result,
   input  logic                     i_rsp_ready
);
   localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [ID_W-1:0]  rr_ptr;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_any;
   logic [ID_W:0]    scan_sum;
   logic [ID_W-1:0]  scan_idx;
   logic [CNT_W-1:0] exec_cnt;
   logic [WIDTH-1:0] sel_term1;
   logic [WIDTH-1:0] sel_term2;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   ripple_carry_adder_19bit #(.WIDTH(WIDTH)) u_adder (
      .a         (op_a),
      .b         (op_b),
      .sum       (add_sum),
      .carry_out (add_cout)
   );

   // first valid requester scanning upward from rr_ptr, modulo NUM_REQ
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (scan_sum >= (ID_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[ID_W-1:0];
         if (!grant_any && i_req_valid[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   always_comb begin
      sel_term1 = '0;
      sel_term2 = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (ID_W'(k) == grant_idx) begin
            sel_term1 = i_req_term1[k*WIDTH +: WIDTH];
            sel_term2 = i_req_term2[k*WIDTH +: WIDTH];
         end
      end
   end

   // ready is suppressed while reset is asserted so no handshake can appear during reset
   always_comb begin
      o_req_ready = '0;
      if (i_rst_n && state == IDLE && grant_any) begin
         o_req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = EXEC;
         EXEC:    if (exec_cnt == '0) state_nxt = RESP;
         RESP:    if (i_rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr       <= '0;
         exec_cnt     <= '0;
         op_a         <= '0;
         op_b         <= '0;
         o_rsp_valid  <= 1'b0;
         o_rsp_id     <= '0;
         o_rsp_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  op_a     <= sel_term1;
                  op_b     <= sel_term2;
                  o_rsp_id <= grant_idx;
                  rr_ptr   <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                  exec_cnt <= CNT_W'(EXEC_CYCLES-1);
               end
            end
            EXEC: begin
               if (exec_cnt == '0) begin
                  o_rsp_result <= {add_cout, add_sum};
                  o_rsp_valid  <= 1'b1;
               end else begin
                  exec_cnt <= exec_cnt - 1'b1;
               end
            end
            RESP: begin
               if (i_rsp_ready) begin
                  o_rsp_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one combinational `ripple_carry_adder_19bit` instance among NUM_REQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Operands are captured into registers, and the adder output gets EXEC_CYCLES cycles to settle (multicycle path through the ripple chain).
- The sum is returned with the requester ID on a single response channel with backpressure.
- Sits between requesting datapath blocks and the shared adder.

Parameters:
- WIDTH, 19, operand width; the sum is WIDTH+1 bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- EXEC_CYCLES, 2, cycles operands are held on the adder before the result is sampled (>=1).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_term1  in  NUM_REQ*WIDTH  packed operand 1; requester k uses bits [k*WIDTH +: WIDTH].
- i_req_term2  in  NUM_REQ*WIDTH  packed operand 2, same packing.
- o_req_ready  out  NUM_REQ  one-hot accept strobe to the granted requester.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  ID_W  index of the requester whose result is presented.
- o_rsp_result  out  WIDTH+1  {carry_out, sum} of the captured operands.
- i_rsp_ready  in  1  response sink ready.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=0; exec counter=0.
  - Operand registers=0.
  - o_req_ready=0, o_rsp_valid=0, o_rsp_id=0, o_rsp_result=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any i_req_valid is set, select the first set bit scanning rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - o_req_ready[g]=1 combinationally in that cycle; the handshake completes when valid&ready.
  - On that edge: capture term1/term2 of g, store g as the ID, rr_ptr <= (g+1) mod NUM_REQ, counter <= EXEC_CYCLES-1, go to EXEC.
  - No valid set: stay in IDLE with all o_req_ready=0.
- EXEC:
  - Operand registers drive the adder and are held stable.
  - o_req_ready=0 throughout.
  - If counter==0: register the adder output into o_rsp_result, set o_rsp_valid=1, go to RESP. Otherwise decrement the counter.
- RESP:
  - o_rsp_valid, o_rsp_id and o_rsp_result are held stable until i_rsp_ready=1.
  - On the valid&ready edge: o_rsp_valid <= 0, go to IDLE.
  - Requests arriving here are not accepted; new arbitration starts the cycle after return to IDLE.
- Latency and throughput:
  - Accept at edge T gives o_rsp_valid high after edge T+EXEC_CYCLES.
  - With i_rsp_ready tied high, one transaction completes every EXEC_CYCLES+2 cycles.
- Arithmetic: o_rsp_result = term1 + term2, zero-extended to WIDTH+1. The MSB is the carry out. There is no carry in and no saturation.
- Boundary conditions:
  - Requester dropping valid before grant: no effect; the arbiter samples valid only in IDLE.
  - Requester dropping valid while granted: ignored (ready is only ever given in IDLE).
  - All requesters valid: grants rotate strictly, with no starvation.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-transaction: the transaction is dropped, with no response.

Test Plan:
- Single request: req0 valid, term1=19'h7FFFF, term2=19'h00001 → o_req_ready[0] one cycle; o_rsp_valid 3 cycles later (EXEC_CYCLES=2) with id=0, result=20'h80000.
- Zero operands: req2 with 0+0 → result=20'h00000, id=2, carry=0.
- Fairness: all 4 valid continuously, i_rsp_ready=1 → grant order 0,1,2,3,0,1; each result equals its requester's sum.
- Backpressure: i_rsp_ready=0 for 5 cycles during RESP → o_rsp_valid, id and result unchanged; no o_req_ready; release → next grant.
- Pointer wrap: rr_ptr=3 after a grant to req2, only req1 and req3 valid → req3 granted first, then req1.
- Async reset asserted in EXEC → all outputs 0 immediately; after release, rr_ptr=0 and no stale response.
